// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register for the 5-stage MIPS core. Captures the fetch PC
// and the instruction word and presents them to decode. A fetch from a
// misaligned or out-of-text-segment address becomes a NOP tagged AdEL.
// The register supports hazard stall (hold) and flush (bubble). It carries
// the delay-slot flag and PC+8 for link instructions. It also keeps
// saturating stall/flush event counters.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   stall, flush       hazard hold / bubble insert (flush wins)
//   in_pc, in_instr    fetch address and instruction memory data
//   in_bd              fetched instruction sits in a branch delay slot
//   id_pc, id_pc8      PC of the ID instruction and its link value (PC+8)
//   id_instr           ID instruction word (0 for bubble or fault)
//   id_valid           ID holds a real instruction (faulting fetches count)
//   id_bd              delay-slot flag of the ID instruction
//   id_exc, id_exccode fetch fault flag and code (4 = AdEL)
//   stall_cnt          honoured stall cycles (saturating)
//   flush_cnt          honoured flush cycles (saturating)
// ---------------------------------------------------------------------------
module if_id_reg #(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter logic [31:0] TEXT_END  = 32'h0000_6FFC,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  input  logic             in_bd,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc8,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic             id_bd,
  output logic             id_exc,
  output logic [4:0]       id_exccode,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [4:0]       EXC_ADEL = 5'd4;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc8_q, pc8_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             bd_q, bd_d;
  logic             exc_q, exc_d;
  logic [4:0]       exccode_q, exccode_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic fetch_fault;

  assign fetch_fault = (in_pc[1:0] != 2'b00) | (in_pc < TEXT_BASE) | (in_pc > TEXT_END);

  always_comb begin
    pc_d        = pc_q;
    pc8_d       = pc8_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    bd_d        = bd_q;
    exc_d       = exc_q;
    exccode_d   = exccode_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (flush) begin
      // The bubble keeps the fetch PC so it can be traced in the pipeline.
      pc_d      = in_pc;
      pc8_d     = in_pc + 32'd8;
      instr_d   = 32'h0;
      valid_d   = 1'b0;
      bd_d      = 1'b0;
      exc_d     = 1'b0;
      exccode_d = 5'd0;
      if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else if (stall) begin
      if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      pc_d    = in_pc;
      pc8_d   = in_pc + 32'd8;
      bd_d    = in_bd;
      valid_d = 1'b1;
      if (fetch_fault) begin
        instr_d   = 32'h0;
        exc_d     = 1'b1;
        exccode_d = EXC_ADEL;
      end else begin
        instr_d   = in_instr;
        exc_d     = 1'b0;
        exccode_d = 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= TEXT_BASE;
      pc8_q       <= TEXT_BASE + 32'd8;
      instr_q     <= 32'h0;
      valid_q     <= 1'b0;
      bd_q        <= 1'b0;
      exc_q       <= 1'b0;
      exccode_q   <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc8_q       <= pc8_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      bd_q        <= bd_d;
      exc_q       <= exc_d;
      exccode_q   <= exccode_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign id_pc      = pc_q;
  assign id_pc8     = pc8_q;
  assign id_instr   = instr_q;
  assign id_valid   = valid_q;
  assign id_bd      = bd_q;
  assign id_exc     = exc_q;
  assign id_exccode = exccode_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_bd;
  logic [31:0] in_pc, in_instr;

  logic [31:0] id_pc, id_pc8, id_instr;
  logic        id_valid, id_bd, id_exc;
  logic [4:0]  id_exccode;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] s_pc, s_pc8, s_instr;
  logic        s_valid, s_bd, s_exc;
  logic [4:0]  s_exccode;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_id_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd),
    .id_pc(id_pc), .id_pc8(id_pc8), .id_instr(id_instr),
    .id_valid(id_valid), .id_bd(id_bd), .id_exc(id_exc),
    .id_exccode(id_exccode), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd),
    .id_pc(s_pc), .id_pc8(s_pc8), .id_instr(s_instr),
    .id_valid(s_valid), .id_bd(s_bd), .id_exc(s_exc),
    .id_exccode(s_exccode), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set beforehand are sampled on this edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic [31:0] pc, input logic [31:0] ins, input logic bd);
    rst = r; stall = s; flush = f; in_pc = pc; in_instr = ins; in_bd = bd;
  endtask

  task automatic chk_fault(input string tag, input logic [31:0] pc);
    drive(0, 0, 0, pc, 32'hDEAD_BEEF, 0);
    step(1);
    chk({tag, "_exc"},   {31'b0, id_exc}, 32'd1);
    chk({tag, "_code"},  {27'b0, id_exccode}, 32'd4);
    chk({tag, "_instr"}, id_instr, 32'h0);
    chk({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
    chk({tag, "_pc"},    id_pc, pc);
  endtask

  initial begin
    // T1: reset overrides stall and flush
    drive(1, 1, 1, 32'h0000_1234, 32'h1111_1111, 1);
    step(2);
    chk("rst_pc",      id_pc, 32'h3000);
    chk("rst_pc8",     id_pc8, 32'h3008);
    chk("rst_instr",   id_instr, 32'h0);
    chk("rst_valid",   {31'b0, id_valid}, 32'd0);
    chk("rst_bd",      {31'b0, id_bd}, 32'd0);
    chk("rst_exc",     {31'b0, id_exc}, 32'd0);
    chk("rst_code",    {27'b0, id_exccode}, 32'd0);
    chk("rst_scnt",    {16'b0, stall_cnt}, 32'd0);
    chk("rst_fcnt",    {16'b0, flush_cnt}, 32'd0);

    // T2: plain load
    drive(0, 0, 0, 32'h3004, 32'h2401_0001, 1);
    step(1);
    chk("ld_instr", id_instr, 32'h2401_0001);
    chk("ld_pc",    id_pc, 32'h3004);
    chk("ld_pc8",   id_pc8, 32'h300C);
    chk("ld_valid", {31'b0, id_valid}, 32'd1);
    chk("ld_bd",    {31'b0, id_bd}, 32'd1);
    chk("ld_exc",   {31'b0, id_exc}, 32'd0);

    // T3: stall holds for 3 cycles, then release
    drive(0, 1, 0, 32'h3008, 32'hFFFF_FFFF, 0);
    step(3);
    chk("st_instr", id_instr, 32'h2401_0001);
    chk("st_pc",    id_pc, 32'h3004);
    chk("st_pc8",   id_pc8, 32'h300C);
    chk("st_bd",    {31'b0, id_bd}, 32'd1);
    chk("st_valid", {31'b0, id_valid}, 32'd1);
    chk("st_scnt",  {16'b0, stall_cnt}, 32'd3);
    chk("st_fcnt",  {16'b0, flush_cnt}, 32'd0);
    stall = 0;
    step(1);
    chk("rel_instr", id_instr, 32'hFFFF_FFFF);
    chk("rel_pc",    id_pc, 32'h3008);
    chk("rel_bd",    {31'b0, id_bd}, 32'd0);
    chk("rel_scnt",  {16'b0, stall_cnt}, 32'd3);

    // T4: flush beats stall
    drive(0, 1, 1, 32'h3010, 32'h1234_5678, 1);
    step(1);
    chk("fl_valid", {31'b0, id_valid}, 32'd0);
    chk("fl_instr", id_instr, 32'h0);
    chk("fl_pc",    id_pc, 32'h3010);
    chk("fl_pc8",   id_pc8, 32'h3018);
    chk("fl_bd",    {31'b0, id_bd}, 32'd0);
    chk("fl_fcnt",  {16'b0, flush_cnt}, 32'd1);
    chk("fl_scnt",  {16'b0, stall_cnt}, 32'd3);

    // T5: fetch faults and boundaries
    chk_fault("f_mis", 32'h3002);
    chk_fault("f_hi",  32'h7000);
    chk_fault("f_lo",  32'h2FFC);
    drive(0, 0, 0, 32'h6FFC, 32'h8C22_0000, 0);
    step(1);
    chk("top_exc",   {31'b0, id_exc}, 32'd0);
    chk("top_code",  {27'b0, id_exccode}, 32'd0);
    chk("top_instr", id_instr, 32'h8C22_0000);
    chk("top_pc8",   id_pc8, 32'h7004);
    drive(0, 0, 0, 32'h3000, 32'h0000_000C, 0);
    step(1);
    chk("base_exc",   {31'b0, id_exc}, 32'd0);
    chk("base_instr", id_instr, 32'h0000_000C);
    // Fault then flush: bubble must clear the exception tag
    chk_fault("f_pre", 32'h7000);
    drive(0, 0, 1, 32'h7000, 32'hDEAD_BEEF, 0);
    step(1);
    chk("flx_exc",  {31'b0, id_exc}, 32'd0);
    chk("flx_code", {27'b0, id_exccode}, 32'd0);
    chk("flx_fcnt", {16'b0, flush_cnt}, 32'd2);

    // Reset in the middle of a stall clears at once
    drive(0, 1, 0, 32'h3020, 32'h0, 0);
    step(2);
    chk("mid_scnt", {16'b0, stall_cnt}, 32'd5);
    rst = 1;
    step(1);
    chk("mid_rst_scnt",  {16'b0, stall_cnt}, 32'd0);
    chk("mid_rst_fcnt",  {16'b0, flush_cnt}, 32'd0);
    chk("mid_rst_valid", {31'b0, id_valid}, 32'd0);
    chk("mid_rst_pc",    id_pc, 32'h3000);

    // T6: saturation on the 4-bit counter instance
    chk("sat_init", {28'b0, s_stall_cnt}, 32'd0);
    rst = 0;
    step(15);
    chk("sat_15",  {28'b0, s_stall_cnt}, 32'hF);
    step(5);
    chk("sat_20",  {28'b0, s_stall_cnt}, 32'hF);
    chk("wide_20", {16'b0, stall_cnt}, 32'd20);
    chk("sat_fcnt", {28'b0, s_flush_cnt}, 32'd0);
    rst = 1;
    step(1);
    chk("sat_rst", {28'b0, s_stall_cnt}, 32'd0);
    chk("wide_rst", {16'b0, stall_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
